ghazi_prog_loader: RTL and testbench
====================================

# ghazi_prog_loader

Parametrised successor to the single-target UART program loader. It consumes the received byte stream from the UART receiver and decodes checksummed frames. Each frame either writes words into one of `N_CH` target memories (instruction RAM, data RAM, …) or releases/holds the core reset. It sits in the top wrapper between `uart_rx_prog` and the RAM port muxes, and drives the core's active-low reset.

## Interface
Parameters:
- `ADDR_W`, 14, word address width; address field is `AB = ceil(ADDR_W/8)` bytes, unused high bits ignored
- `DATA_W`, 32, word width, multiple of 8; `DB = DATA_W/8` bytes per word
- `N_CH`, 2, number of target memories, 1..64
- `TIMEOUT_CYC`, 100000, idle cycles inside a frame before abort, ≥2

Ports:
- `wb_clk_i`  in  1  single clock
- `wb_rst_i`  in  1  reset, synchronous, active-high
- `rx_dv_i`  in  1  one-cycle strobe: `rx_byte_i` valid; may assert every cycle
- `rx_byte_i`  in  8  received byte
- `we_o`  out  N_CH  one-hot write strobe to the selected memory
- `addr_o`  out  ADDR_W  word address
- `wdata_o`  out  DATA_W  write data
- `core_rst_no`  out  1  core reset, low = held
- `busy_o`  out  1  high while a frame is in progress (state ≠ IDLE)
- `err_o`  out  1  sticky error flag
- `err_code_o`  out  2  first error: 1 = bad command, 2 = checksum, 3 = timeout

## Operation
- Frame layout. `cmd` byte: `[7:6]` is op, `[5:0]` is channel. The `cmd` byte is followed by op-specific bytes, then one checksum byte.
- Checksum = 8-bit modular sum of every frame byte before it.
- op 00 WRITE: `cmd`, then `AB` address bytes (LSB first), then count byte `N` (0 means 256 words), then `N×DB` data bytes (LSB first per word), then checksum.
- op 01 RUN and op 11 HALT: `cmd`, checksum. Channel field is ignored.
- op 10 is reserved.
- States and transitions:
  - IDLE → ADDR (WRITE), CSUM (RUN/HALT), or IDLE with error 1.
  - ADDR → CNT after `AB` bytes.
  - CNT → DATA.
  - DATA → CSUM after `N` words.
  - CSUM → IDLE.
- Bad command, raising error 1 and staying in IDLE:
  - op 10
  - WRITE with channel ≥ `N_CH`
  - WRITE while `core_rst_no` = 1
- Each completed word issues one write to the current address. The address increments by 1 modulo 2^ADDR_W, so 2^ADDR_W−1 wraps to 0.
- Writes are not buffered. A checksum mismatch (error 2) does not undo writes already issued.
- RUN with a correct checksum and `err_o` = 0 sets `core_rst_no` = 1. Otherwise `core_rst_no` is unchanged and a mismatch records error 2.
- HALT with a correct checksum clears `core_rst_no`, `err_o` and `err_code_o`.
- Timeout: outside IDLE, `TIMEOUT_CYC` consecutive cycles without `rx_dv_i` abort to IDLE with error 3. A byte arriving on the expiry cycle wins and restarts the count.
- Errors: `err_code_o` latches the first error only. It is held until HALT or reset.

## Timing
- Reset values: state IDLE, `we_o` = 0, `addr_o` = 0, `wdata_o` = 0, `core_rst_no` = 0, `busy_o` = 0, `err_o` = 0, `err_code_o` = 0.
- Reset mid-frame aborts the frame; no write is issued.
- `we_o` is registered and high for exactly 1 cycle, the cycle after the last byte of a word is accepted. `addr_o`/`wdata_o` are valid in that same cycle and hold until the next write.
- Back-to-back bytes every cycle must be sustained with no byte loss.
- `core_rst_no`, `err_o` and `err_code_o` update the cycle after the deciding byte (checksum or bad `cmd`).
- `busy_o` rises the cycle after `cmd` is accepted and falls the cycle after the frame ends.

## Test plan
All scenarios use the defaults `ADDR_W` = 14, `DATA_W` = 32, `N_CH` = 2.
1. WRITE ch0: bytes `00 10 00 02 44 33 22 11 88 77 66 55 76` → `we_o` = 01 pulses twice: addr 0x0010 / data 0x11223344, then 0x0011 / 0x55667788; `err_o` = 0.
2. RUN `40 40` after scenario 1 → `core_rst_no` = 1 one cycle after the second byte. A following WRITE `cmd` `00` → `err_code_o` = 1, no `we_o`.
3. HALT `C0 C0`, then WRITE ch1 at addr 0x3FFF, 2 words, with a wrong checksum → `we_o` = 10 at 0x3FFF then 0x0000, `err_code_o` = 2. A following RUN `40 40` leaves `core_rst_no` = 0.
4. Bytes `00 10`, then silence for `TIMEOUT_CYC` cycles → `busy_o` = 0, `err_code_o` = 3. Repeat with a byte on the expiry cycle → no error.
5. `cmd` `05` (channel 5 ≥ `N_CH`) and `cmd` `80` → error 1 latched, no writes; the later code does not overwrite the first.
6. Assert `wb_rst_i` during DATA of scenario 1 → all outputs at reset values next cycle, no pending write. Scenario 1 then completes normally.

Source files
------------

// File: rtl/ghazi_prog_loader.sv
// Framed UART program loader: checksummed WRITE frames into N_CH memories,
// plus RUN/HALT frames that control the core's active-low reset.
module ghazi_prog_loader #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 32,
    parameter int N_CH        = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              rx_dv_i,
    input  logic [7:0]        rx_byte_i,
    output logic [N_CH-1:0]   we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              core_rst_no,
    output logic              busy_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam int AB   = (ADDR_W + 7) / 8;
    localparam int DB   = DATA_W / 8;
    localparam int MAXB = (AB > DB) ? AB : DB;
    localparam int BC_W = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam int TC_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CNT,
        DATA,
        CSUM
    } state_t;

    state_t state, state_d;

    logic [7:0]        sum;
    logic [1:0]        op_q;
    logic [5:0]        ch_q;
    logic [BC_W-1:0]   byte_cnt;
    logic [8:0]        word_cnt;
    logic [ADDR_W-1:0] addr_ptr;
    logic [DATA_W-1:0] data_acc;
    logic [DATA_W-1:0] word_next;
    logic [TC_W-1:0]   tmo_cnt;

    logic       tmo_hit;
    logic       set_err;
    logic [1:0] err_val;
    logic       wr_fire;
    logic       run_ok;
    logic       halt_ok;
    logic       last_addr;
    logic       last_byte;
    logic       csum_ok;
    logic       cmd_bad;

    assign busy_o    = (state != IDLE);
    assign last_addr = (byte_cnt == BC_W'(AB - 1));
    assign last_byte = (byte_cnt == BC_W'(DB - 1));
    assign csum_ok   = (rx_byte_i == sum);
    assign tmo_hit   = busy_o && !rx_dv_i
                     && (tmo_cnt == TC_W'(TIMEOUT_CYC - 1));
    assign cmd_bad   = ({1'b0, rx_byte_i[5:0]} >= 7'(N_CH))
                     || core_rst_no;

    always_comb begin
        word_next = data_acc;
        for (int k = 0; k < DB; k++) begin
            if (byte_cnt == BC_W'(k)) begin
                word_next[8*k +: 8] = rx_byte_i;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        set_err = 1'b0;
        err_val = 2'd0;
        wr_fire = 1'b0;
        run_ok  = 1'b0;
        halt_ok = 1'b0;
        if (tmo_hit) begin
            state_d = IDLE;
            set_err = 1'b1;
            err_val = 2'd3;
        end else if (rx_dv_i) begin
            unique case (state)
                IDLE: begin
                    unique case (rx_byte_i[7:6])
                        2'b00: begin
                            if (cmd_bad) begin
                                set_err = 1'b1;
                                err_val = 2'd1;
                            end else begin
                                state_d = ADDR;
                            end
                        end
                        2'b10: begin
                            set_err = 1'b1;
                            err_val = 2'd1;
                        end
                        default: state_d = CSUM;
                    endcase
                end
                ADDR: if (last_addr) state_d = CNT;
                CNT:  state_d = DATA;
                DATA: begin
                    if (last_byte) begin
                        wr_fire = 1'b1;
                        if (word_cnt == 9'd1) state_d = CSUM;
                    end
                end
                CSUM: begin
                    state_d = IDLE;
                    if (csum_ok) begin
                        run_ok  = (op_q == 2'b01) && !err_o;
                        halt_ok = (op_q == 2'b11);
                    end else begin
                        set_err = 1'b1;
                        err_val = 2'd2;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sum         <= '0;
            op_q        <= '0;
            ch_q        <= '0;
            byte_cnt    <= '0;
            word_cnt    <= '0;
            addr_ptr    <= '0;
            data_acc    <= '0;
            tmo_cnt     <= '0;
            we_o        <= '0;
            addr_o      <= '0;
            wdata_o     <= '0;
            core_rst_no <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= 2'd0;
        end else begin
            we_o <= '0;
            if (!busy_o || rx_dv_i) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (rx_dv_i) begin
                unique case (state)
                    IDLE: begin
                        sum      <= rx_byte_i;
                        op_q     <= rx_byte_i[7:6];
                        ch_q     <= rx_byte_i[5:0];
                        byte_cnt <= '0;
                    end
                    ADDR: begin
                        sum <= sum + rx_byte_i;
                        // High bits beyond ADDR_W in the last byte are dropped
                        for (int i = 0; i < ADDR_W; i++) begin
                            if (byte_cnt == BC_W'(i / 8)) begin
                                addr_ptr[i] <= rx_byte_i[i % 8];
                            end
                        end
                        byte_cnt <= last_addr ? '0 : byte_cnt + 1'b1;
                    end
                    CNT: begin
                        sum      <= sum + rx_byte_i;
                        word_cnt <= {(rx_byte_i == 8'd0), rx_byte_i};
                        byte_cnt <= '0;
                    end
                    DATA: begin
                        sum      <= sum + rx_byte_i;
                        data_acc <= word_next;
                        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (wr_fire) begin
                we_o     <= N_CH'(1) << ch_q;
                addr_o   <= addr_ptr;
                wdata_o  <= word_next;
                addr_ptr <= addr_ptr + 1'b1;
                word_cnt <= word_cnt - 1'b1;
            end
            if (run_ok) core_rst_no <= 1'b1;
            if (halt_ok) begin
                core_rst_no <= 1'b0;
                err_o       <= 1'b0;
                err_code_o  <= 2'd0;
            end
            if (set_err) begin
                err_o <= 1'b1;
                if (!err_o) err_code_o <= err_val;
            end
        end
    end

endmodule

// File: tb/tb_ghazi_prog_loader.sv
// Directed bench for ghazi_prog_loader: frames, errors, timeout, reset.
module tb_ghazi_prog_loader;

    localparam int T = 20;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        rx_dv_i = 1'b0;
    logic [7:0]  rx_byte_i = 8'h00;
    logic [1:0]  we_o;
    logic [13:0] addr_o;
    logic [31:0] wdata_o;
    logic        core_rst_no;
    logic        busy_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;

    logic [7:0]  txq[$];
    logic [1:0]  lw[$];
    logic [13:0] la[$];
    logic [31:0] ld[$];
    int          lt[$];

    ghazi_prog_loader #(
        .ADDR_W(14), .DATA_W(32), .N_CH(2), .TIMEOUT_CYC(T)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .rx_dv_i(rx_dv_i),
        .rx_byte_i(rx_byte_i),
        .we_o(we_o),
        .addr_o(addr_o),
        .wdata_o(wdata_o),
        .core_rst_no(core_rst_no),
        .busy_o(busy_o),
        .err_o(err_o),
        .err_code_o(err_code_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    always @(negedge wb_clk_i) begin
        if (we_o != 2'b00) begin
            lw.push_back(we_o);
            la.push_back(addr_o);
            ld.push_back(wdata_o);
            lt.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send();
        foreach (txq[i]) begin
            @(negedge wb_clk_i);
            rx_dv_i   = 1'b1;
            rx_byte_i = txq[i];
        end
        @(negedge wb_clk_i);
        rx_dv_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic clear_log();
        lw.delete();
        la.delete();
        ld.delete();
        lt.delete();
    endtask

    task automatic check_s1(input string pfx);
        check({pfx, " nwr"}, 64'(lw.size()), 64'd2);
        if (lw.size() == 2) begin
            check({pfx, " we0"}, 64'(lw[0]), 64'h1);
            check({pfx, " a0"}, 64'(la[0]), 64'h0010);
            check({pfx, " d0"}, 64'(ld[0]), 64'h11223344);
            check({pfx, " we1"}, 64'(lw[1]), 64'h1);
            check({pfx, " a1"}, 64'(la[1]), 64'h0011);
            check({pfx, " d1"}, 64'(ld[1]), 64'h55667788);
            check({pfx, " gap"}, 64'(lt[1] - lt[0]), 64'd4);
        end
        check({pfx, " err"}, 64'(err_o), 64'd0);
        check({pfx, " busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        idle(3);
        wb_rst_i = 1'b0;
        check("rst we", 64'(we_o), 64'd0);
        check("rst addr", 64'(addr_o), 64'd0);
        check("rst wdata", 64'(wdata_o), 64'd0);
        check("rst core", 64'(core_rst_no), 64'd0);
        check("rst busy", 64'(busy_o), 64'd0);
        check("rst err", 64'(err_o), 64'd0);
        check("rst code", 64'(err_code_o), 64'd0);

        txq = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11,
                8'h88, 8'h77, 8'h66, 8'h55, 8'h76};
        send();
        idle(3);
        check_s1("s1");

        clear_log();
        txq = '{8'h40, 8'h40};
        send();
        check("s2 run", 64'(core_rst_no), 64'd1);
        txq = '{8'h00};
        send();
        check("s2 code", 64'(err_code_o), 64'd1);
        check("s2 busy", 64'(busy_o), 64'd0);
        idle(3);
        check("s2 nwr", 64'(lw.size()), 64'd0);

        txq = '{8'hC0, 8'hC0};
        send();
        check("s3 halt core", 64'(core_rst_no), 64'd0);
        check("s3 halt err", 64'(err_o), 64'd0);
        check("s3 halt code", 64'(err_code_o), 64'd0);
        txq = '{8'h01, 8'hFF, 8'h3F, 8'h02, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
                8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        send();
        idle(2);
        check("s3 nwr", 64'(lw.size()), 64'd2);
        if (lw.size() == 2) begin
            check("s3 we0", 64'(lw[0]), 64'h2);
            check("s3 a0", 64'(la[0]), 64'h3FFF);
            check("s3 d0", 64'(ld[0]), 64'hAABBCCDD);
            check("s3 we1", 64'(lw[1]), 64'h2);
            check("s3 a1", 64'(la[1]), 64'h0000);
            check("s3 d1", 64'(ld[1]), 64'h01020304);
        end
        check("s3 code", 64'(err_code_o), 64'd2);
        txq = '{8'h40, 8'h40};
        send();
        check("s3 run blocked", 64'(core_rst_no), 64'd0);
        check("s3 code kept", 64'(err_code_o), 64'd2);

        clear_log();
        txq = '{8'hC0, 8'hC0};
        send();
        txq = '{8'h05};
        send();
        check("s5 ch code", 64'(err_code_o), 64'd1);
        txq = '{8'h80};
        send();
        check("s5 rsv err", 64'(err_o), 64'd1);
        check("s5 rsv code", 64'(err_code_o), 64'd1);
        txq = '{8'h40, 8'h41};
        send();
        check("s5 csum code", 64'(err_code_o), 64'd1);
        idle(2);
        check("s5 nwr", 64'(lw.size()), 64'd0);

        txq = '{8'hC0, 8'hC0};
        send();
        txq = '{8'h00, 8'h10};
        send();
        idle(T - 1);
        check("s4 pre busy", 64'(busy_o), 64'd1);
        check("s4 pre code", 64'(err_code_o), 64'd0);
        idle(1);
        check("s4 busy", 64'(busy_o), 64'd0);
        check("s4 code", 64'(err_code_o), 64'd3);

        txq = '{8'hC0, 8'hC0};
        send();
        clear_log();
        txq = '{8'h00, 8'h10};
        send();
        idle(T - 2);
        txq = '{8'h00};
        send();
        check("s4b busy", 64'(busy_o), 64'd1);
        check("s4b err", 64'(err_o), 64'd0);
        txq = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h25};
        send();
        idle(2);
        check("s4b nwr", 64'(lw.size()), 64'd1);
        if (lw.size() == 1) begin
            check("s4b a", 64'(la[0]), 64'h0010);
            check("s4b d", 64'(ld[0]), 64'h12345678);
        end
        check("s4b err end", 64'(err_o), 64'd0);

        clear_log();
        txq = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h44, 8'h33};
        send();
        wb_rst_i = 1'b1;
        idle(1);
        wb_rst_i = 1'b0;
        check("s6 we", 64'(we_o), 64'd0);
        check("s6 addr", 64'(addr_o), 64'd0);
        check("s6 wdata", 64'(wdata_o), 64'd0);
        check("s6 busy", 64'(busy_o), 64'd0);
        check("s6 err", 64'(err_o), 64'd0);
        check("s6 code", 64'(err_code_o), 64'd0);
        check("s6 core", 64'(core_rst_no), 64'd0);
        idle(3);
        check("s6 nwr", 64'(lw.size()), 64'd0);
        txq = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11,
                8'h88, 8'h77, 8'h66, 8'h55, 8'h76};
        send();
        idle(3);
        check_s1("s6");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
